// File: rtl/shift_add_mult_ctrl.sv
// Sequencing FSM for the shift-add unsigned multiplier datapath.
// Issues load/clear/add/shift strobes from a start/done handshake.
module shift_add_mult_ctrl #(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             mult_lsb,
    input  logic             mult_zero,
    output logic             load,
    output logic             clear_acc,
    output logic             add_en,
    output logic             shift_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CALC,
        DONE
    } state_t;

    state_t state;
    logic   early;
    logic   last_iter;

    assign early     = (EARLY_EXIT != 0) && mult_zero;
    assign last_iter = (iter_count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            iter_count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    iter_count <= '0;
                    state      <= abort ? IDLE : CALC;
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (early) begin
                        state <= DONE;
                    end else begin
                        iter_count <= iter_count + CNT_W'(1);
                        if (last_iter) state <= DONE;
                    end
                end
                DONE: begin
                    state <= start ? LOAD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes follow the current state so an async reset clears them at once.
    always_comb begin
        load      = (state == LOAD);
        clear_acc = (state == LOAD);
        busy      = (state == LOAD) || (state == CALC);
        done      = (state == DONE);
        shift_en  = (state == CALC) && !abort && !early;
        add_en    = shift_en && mult_lsb;
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Bench for shift_add_mult_ctrl: two controllers (early exit on/off)
// each driving a behavioural shift-add datapath.
`timescale 1ns/1ps
module tb_shift_add_mult_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [7:0] op_m = '0;
    logic [7:0] op_a = '0;

    logic e_lsb, e_zero, e_load, e_clr, e_add, e_shift, e_busy, e_done;
    logic f_lsb, f_zero, f_load, f_clr, f_add, f_shift, f_busy, f_done;
    logic [3:0] e_iter, f_iter;

    logic [7:0]  e_mreg = '0, f_mreg = '0;
    logic [15:0] e_areg = '0, f_areg = '0;
    logic [15:0] e_acc = '0, f_acc = '0;

    int passes = 0;
    int total = 0;

    always #5 clk = ~clk;

    shift_add_mult_ctrl #(.WIDTH(8), .CNT_W(4), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .mult_lsb(e_lsb), .mult_zero(e_zero),
        .load(e_load), .clear_acc(e_clr), .add_en(e_add),
        .shift_en(e_shift), .busy(e_busy), .done(e_done),
        .iter_count(e_iter)
    );

    shift_add_mult_ctrl #(.WIDTH(8), .CNT_W(4), .EARLY_EXIT(0)) u_full (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .mult_lsb(f_lsb), .mult_zero(f_zero),
        .load(f_load), .clear_acc(f_clr), .add_en(f_add),
        .shift_en(f_shift), .busy(f_busy), .done(f_done),
        .iter_count(f_iter)
    );

    assign e_lsb  = e_mreg[0];
    assign e_zero = (e_mreg == 8'd0);
    assign f_lsb  = f_mreg[0];
    assign f_zero = (f_mreg == 8'd0);

    // Datapath models: multiplier shifts right, multiplicand left.
    always @(posedge clk) begin
        if (e_load) begin
            e_mreg <= op_m;
            e_areg <= {8'd0, op_a};
        end else if (e_shift) begin
            e_mreg <= e_mreg >> 1;
            e_areg <= e_areg << 1;
        end
        if (e_clr) e_acc <= '0;
        else if (e_add) e_acc <= e_acc + e_areg;
    end

    always @(posedge clk) begin
        if (f_load) begin
            f_mreg <= op_m;
            f_areg <= {8'd0, op_a};
        end else if (f_shift) begin
            f_mreg <= f_mreg >> 1;
            f_areg <= f_areg << 1;
        end
        if (f_clr) f_acc <= '0;
        else if (f_add) f_acc <= f_acc + f_areg;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic inv();
        chk("e_load_shift", {31'd0, e_load & e_shift}, 32'd0);
        chk("e_add_no_shift", {31'd0, e_add & ~e_shift}, 32'd0);
        chk("e_busy_done", {31'd0, e_busy & e_done}, 32'd0);
        chk("f_load_shift", {31'd0, f_load & f_shift}, 32'd0);
        chk("f_add_no_shift", {31'd0, f_add & ~f_shift}, 32'd0);
        chk("f_busy_done", {31'd0, f_busy & f_done}, 32'd0);
    endtask

    // One full operation on both controllers, checked against arithmetic.
    task automatic run_op(input logic [7:0] m, input logic [7:0] a);
        int n_e, exp_dc_e;
        int dc_e, dc_f, nd_e, nd_f, sh_e, sh_f;
        logic [7:0] av_e, av_f;
        logic [3:0] it_e, it_f;
        logic [15:0] pr_e, pr_f;
        n_e = 0;
        for (int i = 0; i < 8; i++) if (m[i]) n_e = i + 1;
        exp_dc_e = (n_e == 8) ? 10 : n_e + 3;
        dc_e = 0; dc_f = 0; nd_e = 0; nd_f = 0; sh_e = 0; sh_f = 0;
        av_e = '0; av_f = '0; it_e = '0; it_f = '0; pr_e = '0; pr_f = '0;
        @(negedge clk);
        op_m = m;
        op_a = a;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("e_load_c1", {30'd0, e_load, e_clr}, 32'd3);
                chk("f_load_c1", {30'd0, f_load, f_clr}, 32'd3);
            end
            inv();
            if (e_shift && sh_e < 8) begin
                av_e[sh_e] = e_add;
                sh_e++;
            end
            if (f_shift && sh_f < 8) begin
                av_f[sh_f] = f_add;
                sh_f++;
            end
            if (e_done) begin
                nd_e++; dc_e = c; it_e = e_iter; pr_e = e_acc;
            end
            if (f_done) begin
                nd_f++; dc_f = c; it_f = f_iter; pr_f = f_acc;
            end
        end
        chk("e_done_cycle", dc_e, exp_dc_e);
        chk("e_done_count", nd_e, 1);
        chk("e_iter", {28'd0, it_e}, n_e);
        chk("e_shifts", sh_e, n_e);
        chk("e_add_pattern", {24'd0, av_e}, {24'd0, m});
        chk("e_product", {16'd0, pr_e}, m * a);
        chk("f_done_cycle", dc_f, 10);
        chk("f_done_count", nd_f, 1);
        chk("f_iter", {28'd0, it_f}, 8);
        chk("f_shifts", sh_f, 8);
        chk("f_add_pattern", {24'd0, av_f}, {24'd0, m});
        chk("f_product", {16'd0, pr_f}, m * a);
    endtask

    initial begin
        int dn, first_dc, second_dc;

        // Reset state, held and first cycle after release.
        repeat (2) @(negedge clk);
        chk("rst_strobes", {26'd0, e_load, e_clr, e_add, e_shift, e_busy, e_done}, 0);
        chk("rst_iter", {28'd0, e_iter}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rel_strobes", {26'd0, f_load, f_clr, f_add, f_shift, f_busy, f_done}, 0);
        chk("rel_iter", {28'd0, f_iter}, 0);

        // Abort ignored in IDLE.
        abort = 1'b1;
        @(negedge clk);
        chk("idle_abort", {30'd0, e_busy, f_busy}, 0);
        abort = 1'b0;

        // Directed operands then random ones.
        run_op(8'hFF, 8'hFF);
        run_op(8'h05, 8'h09);
        run_op(8'h00, 8'h37);
        run_op(8'h80, 8'h01);
        for (int k = 0; k < 20; k++)
            run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

        // Start ignored while busy; then held through DONE for back-to-back.
        @(negedge clk);
        op_m = 8'h05;
        op_a = 8'h03;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dn = 0; first_dc = 0; second_dc = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            inv();
            if (c == 4 || c == 7) chk("busy_at_start", {31'd0, f_busy}, 1);
            if (c == 11) chk("b2b_load", {31'd0, f_load}, 1);
            if (f_done) begin
                dn++;
                if (first_dc == 0) first_dc = c;
                else if (second_dc == 0) second_dc = c;
            end
            if (c == 10) chk("ignored_starts", dn, 1);
            start = (c == 4 || c == 7 || c == 10);
        end
        start = 1'b0;
        chk("first_done", first_dc, 10);
        chk("second_done", second_dc, 20);
        chk("b2b_done_count", dn, 2);
        repeat (2) @(negedge clk);

        // Abort with start in the third CALC cycle.
        op_m = 8'hFF;
        op_a = 8'h11;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_iter", {28'd0, f_iter}, 2);
        abort = 1'b1;
        start = 1'b1;
        #1;
        chk("abort_strobes", {28'd0, e_shift, e_add, f_shift, f_add}, 0);
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_idle", {28'd0, f_busy, f_done, e_busy, e_done}, 0);
        chk("abort_iter_f", {28'd0, f_iter}, 2);
        chk("abort_iter_e", {28'd0, e_iter}, 2);
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            dn += int'(f_done) + int'(e_done) + int'(f_busy) + int'(e_busy);
        end
        chk("abort_no_done", dn, 0);
        run_op(8'hA7, 8'h5C);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        op_m = 8'hFF;
        op_a = 8'h22;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_shift", {30'd0, f_shift, f_busy}, 3);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out", {28'd0, f_busy, f_shift, f_add, e_busy}, 0);
        chk("async_rst_iter", {28'd0, f_iter}, 0);
        @(negedge clk);
        reset = 1'b0;
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            dn += int'(f_done) + int'(e_done) + int'(f_busy) + int'(e_busy);
        end
        chk("post_rst_quiet", dn, 0);
        run_op(8'h3C, 8'hC3);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
